// File: rtl/sc_seq_ctrl.sv
// sc_seq_ctrl: UART command sequencer driving the stream-cipher datapath strobes
module sc_seq_ctrl #(
   parameter int KEY_NIBBLES = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   bu_rx_data_rdy,
   input  logic                   de_bigE,
   input  logic                   de_bigD,
   input  logic                   de_bigL,
   input  logic                   de_hex,
   input  logic                   de_cr,
   input  logic                   scdCharIsValid,
   input  logic                   tx_full,
   output logic                   sccEncrypt,
   output logic                   sccDecrypt,
   output logic                   sccEldByte,
   output logic                   sccEmsBitsLd,
   output logic                   sccElsBitsLd,
   output logic                   sccEmsBitsSl,
   output logic                   sccDnibble1En,
   output logic                   sccDnibble2En,
   output logic [KEY_NIBBLES-1:0] sccLdKey,
   output logic                   sccLdLFSR,
   output logic                   sccStep,
   output logic                   L4_tx_data_rdy,
   output logic                   L4_PrintBuf,
   output logic [4:0]             L4_led
);
   typedef enum logic [3:0] {
      IDLE, KEY, KEY_DONE, ENC_WAIT, ENC_CAP, ENC_MS, ENC_LS, DEC_N1, DEC_N2, DEC_TX
   } state_t;

   localparam int CW = $clog2(KEY_NIBBLES + 1);
   localparam logic [KEY_NIBBLES-1:0] MSB_BIT = {1'b1, {(KEY_NIBBLES-1){1'b0}}};

   state_t        state;
   logic [CW-1:0] cnt;
   logic          ovr;
   logic          pend;
   logic          rx_cr;
   logic          rx_oth;
   logic          busy;
   logic          pend_nx;

   assign rx_cr   = bu_rx_data_rdy & de_cr;
   assign rx_oth  = bu_rx_data_rdy & ~de_cr;
   assign busy    = state inside {ENC_CAP, ENC_MS, ENC_LS, DEC_TX};
   // a CR arriving on the final transmit cycle still ends the session
   assign pend_nx = pend | (busy & rx_cr);

   assign sccEncrypt     = state inside {ENC_WAIT, ENC_CAP, ENC_MS, ENC_LS};
   assign sccDecrypt     = state inside {DEC_N1, DEC_N2, DEC_TX};
   assign sccEldByte     = (state == ENC_WAIT) & rx_oth & scdCharIsValid;
   assign sccEmsBitsLd   = state == ENC_CAP;
   assign sccElsBitsLd   = state == ENC_CAP;
   assign sccEmsBitsSl   = state == ENC_MS;
   assign sccDnibble1En  = (state == DEC_N1) & rx_oth & de_hex;
   assign sccDnibble2En  = (state == DEC_N2) & rx_oth & de_hex;
   assign sccStep        = (state == ENC_CAP) | ((state == DEC_TX) & ~tx_full);
   assign L4_tx_data_rdy = ~tx_full & (state inside {ENC_MS, ENC_LS, DEC_TX});
   assign L4_PrintBuf    = rx_cr;
   assign L4_led         = {state == IDLE, ovr, state inside {KEY, KEY_DONE}, sccDecrypt, sccEncrypt};

   // command FSM plus registered key/LFSR load pulses, overrun and pending-CR flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         ovr       <= 1'b0;
         pend      <= 1'b0;
         sccLdKey  <= '0;
         sccLdLFSR <= 1'b0;
      end else begin
         sccLdKey  <= '0;
         sccLdLFSR <= 1'b0;
         pend      <= pend_nx;
         if (busy && rx_oth) ovr <= 1'b1;
         case (state)
            IDLE:
               if (rx_oth && (de_bigE || de_bigD || de_bigL)) begin
                  ovr   <= 1'b0;
                  cnt   <= '0;
                  state <= de_bigE ? ENC_WAIT : de_bigD ? DEC_N1 : KEY;
               end
            KEY:
               if (rx_cr) state <= IDLE;
               else if (rx_oth && de_hex) begin
                  sccLdKey <= MSB_BIT >> cnt;
                  cnt      <= cnt + CW'(1);
                  if (cnt == CW'(KEY_NIBBLES - 1)) state <= KEY_DONE;
               end
            KEY_DONE:
               if (rx_cr) begin
                  state     <= IDLE;
                  sccLdLFSR <= 1'b1;
               end
            ENC_WAIT:
               if (rx_cr) state <= IDLE;
               else if (rx_oth && scdCharIsValid) state <= ENC_CAP;
            ENC_CAP: state <= ENC_MS;
            ENC_MS: if (!tx_full) state <= ENC_LS;
            ENC_LS:
               if (!tx_full) begin
                  state <= pend_nx ? IDLE : ENC_WAIT;
                  pend  <= 1'b0;
               end
            DEC_N1:
               if (rx_cr) state <= IDLE;
               else if (rx_oth && de_hex) state <= DEC_N2;
            DEC_N2:
               if (rx_cr) state <= IDLE;
               else if (rx_oth && de_hex) state <= DEC_TX;
            DEC_TX:
               if (!tx_full) begin
                  state <= pend_nx ? IDLE : DEC_N1;
                  pend  <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sc_seq_ctrl.sv
// tb_sc_seq_ctrl: random and directed checks of sc_seq_ctrl against a session-level model
module tb_sc_seq_ctrl;
   localparam int KN = 8;
   localparam logic [7:0] CR = 8'h0d;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          bu_rx_data_rdy, de_bigE, de_bigD, de_bigL, de_hex, de_cr, scdCharIsValid, tx_full;
   logic          sccEncrypt, sccDecrypt, sccEldByte, sccEmsBitsLd, sccElsBitsLd, sccEmsBitsSl;
   logic          sccDnibble1En, sccDnibble2En, sccLdLFSR, sccStep, L4_tx_data_rdy, L4_PrintBuf;
   logic [KN-1:0] sccLdKey;
   logic [4:0]    L4_led;

   always #5 clk = ~clk;

   sc_seq_ctrl #(.KEY_NIBBLES(KN)) dut (
      .clk(clk), .rst_n(rst_n), .bu_rx_data_rdy(bu_rx_data_rdy), .de_bigE(de_bigE),
      .de_bigD(de_bigD), .de_bigL(de_bigL), .de_hex(de_hex), .de_cr(de_cr),
      .scdCharIsValid(scdCharIsValid), .tx_full(tx_full), .sccEncrypt(sccEncrypt),
      .sccDecrypt(sccDecrypt), .sccEldByte(sccEldByte), .sccEmsBitsLd(sccEmsBitsLd),
      .sccElsBitsLd(sccElsBitsLd), .sccEmsBitsSl(sccEmsBitsSl), .sccDnibble1En(sccDnibble1En),
      .sccDnibble2En(sccDnibble2En), .sccLdKey(sccLdKey), .sccLdLFSR(sccLdLFSR),
      .sccStep(sccStep), .L4_tx_data_rdy(L4_tx_data_rdy), .L4_PrintBuf(L4_PrintBuf),
      .L4_led(L4_led)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // session model: mode 0 idle, 1 key entry, 2 encrypt, 3 decrypt
   int            m_mode, m_cnt, m_stage, m_nibs;
   bit            m_pend, m_ovr, m_lfsr;
   logic [KN-1:0] m_ldkey;
   logic [24:0]   obs, expv;

   function automatic logic [24:0] pack_dut();
      return {sccEncrypt, sccDecrypt, sccEldByte, sccEmsBitsLd, sccElsBitsLd, sccEmsBitsSl,
              sccDnibble1En, sccDnibble2En, sccLdKey, sccLdLFSR, sccStep, L4_tx_data_rdy,
              L4_PrintBuf, L4_led};
   endfunction

   // m_stage counts encrypt work left: 3 capture, 2 MS digit, 1 LS digit, 0 awaiting plaintext
   function automatic logic [24:0] model_out();
      bit oth = bu_rx_data_rdy && !de_cr;
      bit enc = m_mode == 2;
      bit dec = m_mode == 3;
      bit txg = !tx_full && ((enc && (m_stage == 1 || m_stage == 2)) || (dec && m_nibs == 2));
      return {enc, dec, enc && m_stage == 0 && oth && scdCharIsValid, enc && m_stage == 3,
              enc && m_stage == 3, enc && m_stage == 2, dec && m_nibs == 0 && oth && de_hex,
              dec && m_nibs == 1 && oth && de_hex, m_ldkey, m_lfsr,
              (enc && m_stage == 3) || (dec && m_nibs == 2 && !tx_full), txg,
              bu_rx_data_rdy && de_cr, m_mode == 0, m_ovr, m_mode == 1, dec, enc};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_stage = 0; m_nibs = 0;
      m_pend = 0; m_ovr = 0; m_lfsr = 0; m_ldkey = '0;
   endtask

   task automatic model_step();
      bit crx, oth, busy;
      crx = bu_rx_data_rdy && de_cr;
      oth = bu_rx_data_rdy && !de_cr;
      busy = (m_mode == 2 && m_stage != 0) || (m_mode == 3 && m_nibs == 2);
      m_ldkey = '0;
      m_lfsr = 0;
      if (busy && crx) m_pend = 1;
      if (busy && oth) m_ovr = 1;
      case (m_mode)
         0: if (oth && (de_bigE || de_bigD || de_bigL)) begin
               m_ovr = 0; m_cnt = 0; m_stage = 0; m_nibs = 0;
               m_mode = de_bigE ? 2 : de_bigD ? 3 : 1;
            end
         1: if (crx) begin
               m_lfsr = m_cnt == KN;
               m_mode = 0;
            end else if (oth && de_hex && m_cnt < KN) begin
               m_ldkey[KN-1-m_cnt] = 1'b1;
               m_cnt++;
            end
         2: if (m_stage == 0) begin
               if (crx) m_mode = 0;
               else if (oth && scdCharIsValid) m_stage = 3;
            end else if (m_stage == 3) m_stage = 2;
            else if (!tx_full) begin
               m_stage--;
               if (m_stage == 0 && m_pend) begin m_mode = 0; m_pend = 0; end
            end
         default: if (m_nibs < 2) begin
               if (crx) m_mode = 0;
               else if (oth && de_hex) m_nibs++;
            end else if (!tx_full) begin
               m_nibs = 0;
               if (m_pend) begin m_mode = 0; m_pend = 0; end
            end
      endcase
   endtask

   task automatic drive(input bit r, input logic [7:0] c, input bit f);
      bu_rx_data_rdy = r;
      de_bigE = c == "E";
      de_bigD = c == "D";
      de_bigL = c == "L";
      de_hex = (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
      de_cr = c == CR;
      scdCharIsValid = c >= 8'h20 && c < 8'h7f;
      tx_full = f;
   endtask

   task automatic check_now();
      obs = pack_dut();
      expv = model_out();
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL outputs @%0t: got %h want %h", $time, obs, expv);
      end
   endtask

   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, act, want);
      end
   endtask

   task automatic tick(input bit r, input logic [7:0] c, input bit f);
      @(negedge clk);
      drive(r, c, f);
      #1 check_now();
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
   endtask

   logic [7:0] chars [13] = '{"E", "D", "L", "0", "1", "4", "9", "A", "F", "x", CR, 8'h01, "z"};

   initial begin
      model_reset();
      drive(0, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      pin("reset_state", 32'(obs), 32'h10);
      rst_n = 1'b1;
      tick(0, 0, 0);
      // key load: one-hot pulse trails each hex by one cycle, MSB nibble first
      tick(1, "L", 0);
      for (int i = 0; i < KN; i++) begin
         tick(1, 8'h31 + 8'(i), 0);
         if (i > 0) pin("ldkey", 32'(obs[16:9]), 32'h80 >> (i - 1));
      end
      tick(1, CR, 0);
      pin("ldkey_last", 32'(obs[16:9]), 32'h01);
      pin("led_key", 32'(obs[2]), 32'h1);
      tick(0, 0, 0);
      pin("ldlfsr", 32'(obs[8]), 32'h1);
      pin("led_idle_after_key", 32'(obs[4:0]), 32'h10);
      tick(0, 0, 0);
      pin("ldlfsr_once", 32'(obs[8]), 32'h0);
      // key abort
      tick(1, "L", 0);
      tick(1, "1", 0);
      tick(1, "2", 0);
      tick(1, "3", 0);
      tick(1, CR, 0);
      pin("abort_ldkey", 32'(obs[16:9]), 32'h20);
      tick(0, 0, 0);
      pin("abort_no_lfsr", 32'(obs[8]), 32'h0);
      pin("abort_idle", 32'(obs[4:0]), 32'h10);
      // encrypt with two stall cycles
      tick(1, "E", 0);
      tick(1, "A", 0);
      pin("eld_byte", 32'(obs[22]), 32'h1);
      tick(0, 0, 0);
      pin("cap_step", 32'({obs[21], obs[20], obs[7]}), 32'h7);
      tick(0, 0, 1);
      pin("ms_stalled", 32'({obs[19], obs[6]}), 32'h2);
      tick(0, 0, 1);
      tick(0, 0, 0);
      pin("ms_tx", 32'({obs[19], obs[6]}), 32'h3);
      tick(0, 0, 0);
      pin("ls_tx", 32'({obs[19], obs[6]}), 32'h1);
      tick(1, CR, 0);
      // decrypt
      tick(1, "D", 0);
      tick(1, "4", 0);
      pin("dnib1", 32'(obs[18]), 32'h1);
      tick(1, "1", 0);
      pin("dnib2", 32'(obs[17]), 32'h1);
      tick(0, 0, 0);
      pin("dec_tx_step", 32'({obs[6], obs[7]}), 32'h3);
      tick(1, CR, 0);
      // overrun and pending CR during a stalled transmit
      tick(1, "E", 0);
      tick(1, "A", 0);
      tick(0, 0, 1);
      tick(1, "x", 1);
      tick(1, CR, 1);
      pin("printbuf", 32'(obs[5]), 32'h1);
      pin("overrun", 32'(obs[3]), 32'h1);
      tick(0, 0, 0);
      pin("ovr_ms_tx", 32'({obs[19], obs[6]}), 32'h3);
      tick(0, 0, 0);
      pin("ovr_ls_tx", 32'({obs[19], obs[6]}), 32'h1);
      tick(0, 0, 0);
      pin("idle_sticky", 32'(obs[4:0]), 32'h18);
      tick(1, "E", 0);
      tick(0, 0, 0);
      pin("ovr_cleared", 32'(obs[4:0]), 32'h01);
      tick(1, CR, 0);
      // asynchronous reset mid key load
      tick(1, "L", 0);
      tick(1, "1", 0);
      #3 rst_n = 1'b0;
      #1 obs = pack_dut();
      pin("async_reset", 32'(obs), 32'h10);
      model_reset();
      tick(0, 0, 0);
      tick(0, 0, 0);
      rst_n = 1'b1;
      tick(0, 0, 0);
      tick(0, 0, 0);
      pin("post_reset_idle", 32'(obs), 32'h10);
      // randomized traffic
      for (int i = 0; i < 4000; i++)
         tick(1'($urandom_range(0, 1)), chars[$urandom_range(0, 12)], $urandom_range(0, 3) == 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
